mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch requester (I, read-only) and its load/store requester (D, read/write with byte enables).
- Supports one outstanding transaction at a time, using a req/gnt/rvalid handshake per requester and a fixed-latency memory.
- D has priority, with a starvation guard that lets a pending fetch win after a bounded run of D grants.
- Sits between the core and the memory, enabling multi-cycle (stalling) core variants.

Parameters:
- MEM_LAT, 2, read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..7.
- D_STREAK, 4, maximum consecutive D grants while i_req is pending before I is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  32  fetch byte address, word-aligned
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  one-cycle pulse, fetch data valid
- i_rdata  out  32  fetch data
- d_req  in  1  data request; held until d_gnt
- d_addr  in  32  data byte address
- d_we  in  4  byte write enables; 0 means read
- d_wdata  in  32  write data, already lane-replicated
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  one-cycle pulse, read data valid or write complete
- d_rdata  out  32  load data; 0 for writes
- mem_en  out  1  memory access strobe
- mem_addr  out  32  memory address
- mem_we  out  4  memory byte write enables
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  transaction outstanding (state != IDLE)

Behaviour:
- Reset (synchronous, active-high; clock clk): state IDLE, streak counter 0. All outputs 0: gnt, rvalid, rdata, mem_en, mem_addr, mem_we, mem_wdata, busy.
- Reset mid-transaction: the outstanding access is dropped. No rvalid is issued for it, and mem_en/mem_we are 0 from the next edge.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Grant is combinational: i_gnt/d_gnt are asserted in the same cycle as the winning req, and only in IDLE, and only when not in reset.
  - Exactly one gnt is asserted per grant.
  - The winner's addr/we/wdata are registered (I always has we=0), the owner is recorded, and the FSM goes to ACCESS.
  - With no req, the FSM stays in IDLE.
- Arbitration:
  - Only d_req: D wins. Only i_req: I wins.
  - Both asserted: D wins unless the streak counter equals D_STREAK, in which case I wins.
  - Streak counter: +1 on each D grant made while i_req=1, saturating at D_STREAK; cleared on any I grant. D grants made while i_req=0 leave it unchanged.
- ACCESS (one cycle):
  - mem_en=1; mem_addr/mem_we/mem_wdata come from the registered values.
  - Write (we!=0): go to RESP.
  - Read: load the wait counter with MEM_LAT-1 and go to WAIT.
- mem_en, mem_we and mem_wdata are 0 in every state except ACCESS. mem_addr holds its last value.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, mem_rdata is valid: capture it into the owner's rdata register and go to RESP.
- RESP (one cycle): the owner's rvalid=1, then back to IDLE.
- A new grant is possible in the first cycle back in IDLE, i.e. the cycle after the rvalid pulse.
- The non-owner's rvalid stays 0.
- rdata holds its value until the next response to the same requester.
- d_rdata=0 on write completion.
- Timing, with the grant in cycle T:
  - mem_en is high in T+1.
  - Read data arrives in T+1+MEM_LAT.
  - Read rvalid is in T+2+MEM_LAT.
  - Write rvalid is in T+2.
- Minimum cycles per transaction: read MEM_LAT+3, write 3.
- Requests deasserted before grant are ignored (no error). Req inputs are ignored while busy=1; gnt stays 0.
- Address bits are passed unmodified; no alignment check.

Test Plan:
- Isolated fetch: MEM_LAT=2, i_req with i_addr=0x100 at cycle T, memory returns 0xDEADBEEF → i_gnt@T, mem_en@T+1 with mem_addr=0x100 and mem_we=0, i_rvalid@T+4 with i_rdata=0xDEADBEEF, d_rvalid never asserted.
- Store: d_req with d_we=4'b0100, d_addr=0x202, d_wdata=0x00AB0000 → mem_we=4'b0100 for exactly one cycle at T+1, d_rvalid@T+2 with d_rdata=0, busy high for T+1..T+2.
- Simultaneous requests: i_req and d_req both continuously high, D_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I,…; i_gnt and d_gnt never high together.
- Back-to-back reads: MEM_LAT=1, D reads 0x10 then 0x14 → second d_gnt exactly one cycle after the first d_rvalid, each d_rdata matching its own address's data.
- Reset mid-WAIT: MEM_LAT=4, reset asserted two cycles after mem_en → no rvalid, all outputs 0, busy=0; a subsequent i_req is granted normally.
- Latency sweep: MEM_LAT=1 and MEM_LAT=7 reads → rvalid at T+3 and T+9 respectively with correct data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between an instruction
//   fetch requester (I, read-only) and a load/store requester (D, byte-enabled
//   read/write). Only one transaction is outstanding at a time. D normally has
//   priority. After D_STREAK consecutive D grants made while a fetch was
//   waiting, the fetch wins the next arbitration.
//
//   Parameters
//     MEM_LAT   read latency, mem_en cycle to valid mem_rdata (1..7)
//     D_STREAK  max back-to-back D grants while i_req is pending (1..15)
//
//   Ports
//     clk, reset               clock, synchronous active-high reset
//     i_req/i_addr             fetch request, held until i_gnt
//     i_gnt/i_rvalid/i_rdata   fetch accept (comb), response pulse, data
//     d_req/d_addr/d_we/d_wdata  data request (d_we==0 means read)
//     d_gnt/d_rvalid/d_rdata   data accept (comb), response pulse, data
//     mem_en/mem_addr/mem_we/mem_wdata/mem_rdata  memory side
//     busy                     a transaction is outstanding
module mem_port_arbiter #(
  parameter int MEM_LAT  = 2,
  parameter int D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state_q;
  logic        own_d_q;      // 1: current transaction belongs to D
  logic [3:0]  streak_q;     // consecutive D grants with a fetch waiting
  logic [2:0]  wcnt_q;       // remaining WAIT cycles
  logic        mem_en_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_we_q;
  logic [31:0] mem_wdata_q;
  logic        i_rvalid_q, d_rvalid_q;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic        busy_q;

  // Arbitration is purely combinational so the grant lands in the request cycle.
  logic can_grant, force_i, d_win, i_win;
  assign can_grant = (state_q == IDLE) && !reset;
  assign force_i   = (streak_q == 4'(D_STREAK));
  assign d_win     = can_grant && d_req && !(i_req && force_i);
  assign i_win     = can_grant && i_req && !d_win;

  assign i_gnt     = i_win;
  assign d_gnt     = d_win;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      own_d_q     <= 1'b0;
      streak_q    <= '0;
      wcnt_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_win || i_win) begin
            state_q     <= ACCESS;
            busy_q      <= 1'b1;
            mem_en_q    <= 1'b1;
            own_d_q     <= d_win;
            mem_addr_q  <= d_win ? d_addr  : i_addr;
            mem_we_q    <= d_win ? d_we    : 4'd0;
            mem_wdata_q <= d_win ? d_wdata : 32'd0;
            // Only D grants that pass over a waiting fetch count toward the streak.
            if (i_win)
              streak_q <= '0;
            else if (i_req && (streak_q < 4'(D_STREAK)))
              streak_q <= streak_q + 4'd1;
          end
        end
        ACCESS: begin
          mem_en_q    <= 1'b0;
          mem_we_q    <= '0;
          mem_wdata_q <= '0;
          if (mem_we_q != 4'd0) begin
            // Writes only ever come from D; completion returns zero data.
            state_q    <= RESP;
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= '0;
          end else begin
            wcnt_q  <= 3'(MEM_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt_q == 3'd0) begin
            state_q <= RESP;
            if (own_d_q) begin
              d_rdata_q  <= mem_rdata;
              d_rvalid_q <= 1'b1;
            end else begin
              i_rdata_q  <= mem_rdata;
              i_rvalid_q <= 1'b1;
            end
          end else begin
            wcnt_q <= wcnt_q - 3'd1;
          end
        end
        RESP: begin
          i_rvalid_q <= 1'b0;
          d_rvalid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
